// File: rtl/i2s_dac_transmitter_if.sv
// Sample-pair stream from the filter path into the I2S DAC transmitter.
// The master offers a left/right pair; the transmitter takes it when in_valid and in_ready are both high.
interface i2s_dac_transmitter_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] in_left;
    logic [SAMPLE_WIDTH-1:0] in_right;
    logic                    in_valid;
    logic                    in_ready;

    modport master (
        output in_left,
        output in_right,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_left,
        input  in_right,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/i2s_dac_transmitter.sv
// I2S serializer for the ADAU1761 DAC line. The codec is the clock master.
// bclk and lrclk are resynchronized into clk, and one sample pair is buffered ahead of the active frame.
module i2s_dac_transmitter #(
    parameter int SAMPLE_WIDTH       = 16,
    parameter int SYNC_STAGES        = 2,
    parameter int UNDERRUN_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bclk,
    input  logic                          lrclk,
    i2s_dac_transmitter_if.slave          smp,
    output logic                          dac_sdata,
    output logic                          frame_start,
    output logic                          underrun,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count
);
    localparam int CNT_W = $clog2(SAMPLE_WIDTH);

    logic [SYNC_STAGES-1:0]  bclk_sync;
    logic [SYNC_STAGES-1:0]  lrclk_sync;
    logic                    bclk_d;
    logic                    bclk_s;
    logic                    lrclk_s;
    logic                    rise_p;
    logic                    fall_p;

    logic [SAMPLE_WIDTH-1:0] pending_l;
    logic [SAMPLE_WIDTH-1:0] pending_r;
    logic                    pending_full;
    logic [SAMPLE_WIDTH-1:0] active_r;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]        bits_left;
    logic                    lr_prev;
    logic                    load_armed;
    logic                    channel;

    logic                    accept;
    logic [SAMPLE_WIDTH-1:0] load_l;
    logic [SAMPLE_WIDTH-1:0] load_r;

    assign bclk_s       = bclk_sync[SYNC_STAGES-1];
    assign lrclk_s      = lrclk_sync[SYNC_STAGES-1];
    assign rise_p       = bclk_s & ~bclk_d;
    assign fall_p       = ~bclk_s & bclk_d;
    assign smp.in_ready = ~pending_full;
    assign accept       = smp.in_valid & ~pending_full;

    // An empty buffer at frame start sends silence for both channels.
    always_comb begin
        load_l = '0;
        load_r = '0;
        if (pending_full) begin
            load_l = pending_l;
            load_r = pending_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            bclk_d     <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], bclk};
            lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], lrclk};
            bclk_d     <= bclk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_l      <= '0;
            pending_r      <= '0;
            pending_full   <= 1'b0;
            active_r       <= '0;
            shift_reg      <= '0;
            bits_left      <= '0;
            lr_prev        <= 1'b0;
            load_armed     <= 1'b0;
            channel        <= 1'b0;
            dac_sdata      <= 1'b0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (accept) begin
                pending_l    <= smp.in_left;
                pending_r    <= smp.in_right;
                pending_full <= 1'b1;
            end

            // lrclk is sampled mid-bit on bclk rise, where it is stable.
            if (rise_p) begin
                if (lrclk_s != lr_prev) begin
                    load_armed <= 1'b1;
                    channel    <= lrclk_s;
                end
                lr_prev <= lrclk_s;
            end

            if (fall_p) begin
                if (load_armed) begin
                    load_armed <= 1'b0;
                    bits_left  <= CNT_W'(SAMPLE_WIDTH - 1);
                    if (!channel) begin
                        frame_start <= 1'b1;
                        active_r    <= load_r;
                        dac_sdata   <= load_l[SAMPLE_WIDTH-1];
                        shift_reg   <= {load_l[SAMPLE_WIDTH-2:0], 1'b0};
                        if (pending_full) begin
                            pending_full <= 1'b0;
                        end else begin
                            underrun <= 1'b1;
                            if (!(&underrun_count))
                                underrun_count <= underrun_count + UNDERRUN_CNT_WIDTH'(1);
                        end
                    end else begin
                        dac_sdata <= active_r[SAMPLE_WIDTH-1];
                        shift_reg <= {active_r[SAMPLE_WIDTH-2:0], 1'b0};
                    end
                end else if (bits_left != '0) begin
                    dac_sdata <= shift_reg[SAMPLE_WIDTH-1];
                    shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], 1'b0};
                    bits_left <= bits_left - CNT_W'(1);
                end else begin
                    // Slot padding past the word is zero.
                    dac_sdata <= 1'b0;
                end
            end
        end
    end
endmodule
